// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the VGA framebuffer arbiter.
// - slot_e: owner of one RAM access slot, carried down the fetch pipeline.
// - DEF_*: default geometry and widths used as parameter defaults.
// - FB_WORDS: framebuffer size in words for the default geometry.
// - red_lsb/grn_lsb: bit offsets of the colour fields in a {R,G,B} RAM word.
package vga_fb_pkg;

   localparam int unsigned DEF_VIDEO_WIDTH = 3;
   localparam int unsigned DEF_ACTIVE_COLS = 320;
   localparam int unsigned DEF_ACTIVE_ROWS = 240;
   localparam int unsigned DEF_ADDR_WIDTH  = 17;
   localparam int unsigned DEF_DATA_WIDTH  = 9;
   localparam int unsigned FB_WORDS        = DEF_ACTIVE_COLS * DEF_ACTIVE_ROWS;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_SCAN,
      SLOT_HOST_RD,
      SLOT_HOST_WR
   } slot_e;

   // Red sits in the top field, blue in the bottom one.
   function automatic int unsigned red_lsb(input int unsigned video_width);
      return 2 * video_width;
   endfunction

   function automatic int unsigned grn_lsb(input int unsigned video_width);
      return video_width;
   endfunction

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Scanout pixel address counter.
// - clk_i, rst_i : pixel clock, synchronous active-high reset
// - active_i     : current cycle is a visible pixel (counter advances)
// - vblank_i     : row count is past the visible area (counter clears)
// - pix_addr_o   : row-major word address of the pixel fetched this cycle
module fb_scan_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 17
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  active_i,
   input  logic                  vblank_i,
   output logic [ADDR_WIDTH-1:0] pix_addr_o
);

   logic [ADDR_WIDTH-1:0] pix_addr_d, pix_addr_q;

   // Visible pixels arrive in row-major order, so a plain increment per
   // active cycle walks the framebuffer without any multiply.
   always_comb begin
      pix_addr_d = pix_addr_q;
      if (vblank_i) begin
         pix_addr_d = '0;
      end else if (active_i) begin
         pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix_addr_q <= '0;
      end else begin
         pix_addr_q <= pix_addr_d;
      end
   end

   assign pix_addr_o = pix_addr_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port synchronous framebuffer RAM between VGA scanout and a
// host port. Scanout owns every slot in the active area; the host is served
// only during blanking, at most once every two cycles.
// Ports:
// - i_Clk, i_Rst                : pixel clock, synchronous active-high reset
// - i_Col_Count, i_Row_Count    : position from the sync generator
// - i_HSync, i_VSync            : raw syncs; o_HSync/o_VSync are them delayed 3
// - i_Host_*                    : host request (hold until o_Host_Ack)
// - o_Host_Ack/Rvalid/Rdata     : grant pulse, read-data pulse, held read data
// - o_Mem_*, i_Mem_Rdata        : registered RAM port, read data one cycle later
// - o_Red/Grn/Blu_Video         : pixel colour, 3 cycles after the fetch slot
// - o_VBlank                    : undelayed, high while row is past visible area
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int unsigned VIDEO_WIDTH = DEF_VIDEO_WIDTH,
   parameter int unsigned ACTIVE_COLS = DEF_ACTIVE_COLS,
   parameter int unsigned ACTIVE_ROWS = DEF_ACTIVE_ROWS,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [9:0]             i_Col_Count,
   input  logic [9:0]             i_Row_Count,
   input  logic                   i_HSync,
   input  logic                   i_VSync,
   input  logic                   i_Host_Req,
   input  logic                   i_Host_We,
   input  logic [ADDR_WIDTH-1:0]  i_Host_Addr,
   input  logic [DATA_WIDTH-1:0]  i_Host_Wdata,
   output logic                   o_Host_Ack,
   output logic                   o_Host_Rvalid,
   output logic [DATA_WIDTH-1:0]  o_Host_Rdata,
   output logic [ADDR_WIDTH-1:0]  o_Mem_Addr,
   output logic                   o_Mem_We,
   output logic [DATA_WIDTH-1:0]  o_Mem_Wdata,
   input  logic [DATA_WIDTH-1:0]  i_Mem_Rdata,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_VBlank
);

   localparam logic [9:0]            COLS_LIM  = 10'(ACTIVE_COLS);
   localparam logic [9:0]            ROWS_LIM  = 10'(ACTIVE_ROWS);
   localparam logic [ADDR_WIDTH-1:0] WORDS_LIM = ADDR_WIDTH'(ACTIVE_COLS * ACTIVE_ROWS);
   localparam int unsigned           RED_LSB   = red_lsb(VIDEO_WIDTH);
   localparam int unsigned           GRN_LSB   = grn_lsb(VIDEO_WIDTH);

   logic                  active, vblank, host_oor;
   logic [ADDR_WIDTH-1:0] pix_addr;

   logic [ADDR_WIDTH-1:0]  mem_addr_d, mem_addr_q;
   logic                   mem_we_d, mem_we_q;
   logic [DATA_WIDTH-1:0]  mem_wdata_d, mem_wdata_q;
   logic                   ack_d, ack_q;
   slot_e                  slot1_d, slot1_q, slot2_d, slot2_q;
   logic                   oor1_d, oor1_q, oor2_d, oor2_q;
   logic                   rvalid_d, rvalid_q;
   logic [DATA_WIDTH-1:0]  rdata_d, rdata_q;
   logic [VIDEO_WIDTH-1:0] red_d, red_q, grn_d, grn_q, blu_d, blu_q;
   logic [2:0]             hs_d, hs_q, vs_d, vs_q;

   assign active   = (i_Col_Count < COLS_LIM) && (i_Row_Count < ROWS_LIM);
   assign vblank   = (i_Row_Count >= ROWS_LIM);
   assign host_oor = (i_Host_Addr >= WORDS_LIM);

   fb_scan_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scan_addr (
      .clk_i      (i_Clk),
      .rst_i      (i_Rst),
      .active_i   (active),
      .vblank_i   (vblank),
      .pix_addr_o (pix_addr)
   );

   always_comb begin
      // Stage 1: pick this cycle's slot owner and register the RAM command.
      slot1_d     = SLOT_IDLE;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      ack_d       = 1'b0;
      oor1_d      = 1'b0;
      if (active) begin
         slot1_d    = SLOT_SCAN;
         mem_addr_d = pix_addr;
      end else if (i_Host_Req && !ack_q) begin
         // The ack_q gate leaves the host one cycle to drop or change its request.
         slot1_d     = i_Host_We ? SLOT_HOST_WR : SLOT_HOST_RD;
         mem_addr_d  = i_Host_Addr;
         mem_we_d    = i_Host_We && !host_oor;
         mem_wdata_d = i_Host_Wdata;
         ack_d       = 1'b1;
         oor1_d      = host_oor;
      end

      // Stage 2: owner tag waits out the RAM read latency.
      slot2_d = slot1_q;
      oor2_d  = oor1_q;

      // Stage 3: RAM data is valid now; steer it to video or the host.
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
      if (slot2_q == SLOT_SCAN) begin
         red_d = i_Mem_Rdata[RED_LSB +: VIDEO_WIDTH];
         grn_d = i_Mem_Rdata[GRN_LSB +: VIDEO_WIDTH];
         blu_d = i_Mem_Rdata[0 +: VIDEO_WIDTH];
      end
      rvalid_d = (slot2_q == SLOT_HOST_RD);
      rdata_d  = rdata_q;
      if (rvalid_d) begin
         rdata_d = oor2_q ? '0 : i_Mem_Rdata;
      end

      hs_d = {hs_q[1:0], i_HSync};
      vs_d = {vs_q[1:0], i_VSync};
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         ack_q       <= 1'b0;
         slot1_q     <= SLOT_IDLE;
         slot2_q     <= SLOT_IDLE;
         oor1_q      <= 1'b0;
         oor2_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         red_q       <= '0;
         grn_q       <= '0;
         blu_q       <= '0;
         hs_q        <= '1;
         vs_q        <= '1;
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         ack_q       <= ack_d;
         slot1_q     <= slot1_d;
         slot2_q     <= slot2_d;
         oor1_q      <= oor1_d;
         oor2_q      <= oor2_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         red_q       <= red_d;
         grn_q       <= grn_d;
         blu_q       <= blu_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
      end
   end

   assign o_Mem_Addr    = mem_addr_q;
   assign o_Mem_We      = mem_we_q;
   assign o_Mem_Wdata   = mem_wdata_q;
   assign o_Host_Ack    = ack_q;
   assign o_Host_Rvalid = rvalid_q;
   assign o_Host_Rdata  = rdata_q;
   assign o_Red_Video   = red_q;
   assign o_Grn_Video   = grn_q;
   assign o_Blu_Video   = blu_q;
   assign o_HSync       = hs_q[2];
   assign o_VSync       = vs_q[2];
   assign o_VBlank      = vblank;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a behavioural synchronous RAM preloaded
// with addr -> addr[8:0] (out-of-range reads return 9'h155), and a linear
// sequence of steps driving col/row counts, syncs and host requests.
module tb_vga_fb_arbiter;

   logic       i_Clk = 1'b0;
   logic       i_Rst;
   logic [9:0] i_Col_Count, i_Row_Count;
   logic       i_HSync, i_VSync;
   logic       i_Host_Req, i_Host_We;
   logic [16:0] i_Host_Addr;
   logic [8:0]  i_Host_Wdata;
   logic        o_Host_Ack, o_Host_Rvalid;
   logic [8:0]  o_Host_Rdata;
   logic [16:0] o_Mem_Addr;
   logic        o_Mem_We;
   logic [8:0]  o_Mem_Wdata;
   logic [8:0]  i_Mem_Rdata;
   logic [2:0]  o_Red_Video, o_Grn_Video, o_Blu_Video;
   logic        o_HSync, o_VSync, o_VBlank;

   int n_cmp  = 0;
   int n_fail = 0;
   int acks;

   logic [8:0] ram [0:76799];

   always #5 i_Clk = ~i_Clk;

   vga_fb_arbiter dut (
      .i_Clk         (i_Clk),
      .i_Rst         (i_Rst),
      .i_Col_Count   (i_Col_Count),
      .i_Row_Count   (i_Row_Count),
      .i_HSync       (i_HSync),
      .i_VSync       (i_VSync),
      .i_Host_Req    (i_Host_Req),
      .i_Host_We     (i_Host_We),
      .i_Host_Addr   (i_Host_Addr),
      .i_Host_Wdata  (i_Host_Wdata),
      .o_Host_Ack    (o_Host_Ack),
      .o_Host_Rvalid (o_Host_Rvalid),
      .o_Host_Rdata  (o_Host_Rdata),
      .o_Mem_Addr    (o_Mem_Addr),
      .o_Mem_We      (o_Mem_We),
      .o_Mem_Wdata   (o_Mem_Wdata),
      .i_Mem_Rdata   (i_Mem_Rdata),
      .o_Red_Video   (o_Red_Video),
      .o_Grn_Video   (o_Grn_Video),
      .o_Blu_Video   (o_Blu_Video),
      .o_HSync       (o_HSync),
      .o_VSync       (o_VSync),
      .o_VBlank      (o_VBlank)
   );

   // Synchronous single-port RAM, read-before-write.
   always @(posedge i_Clk) begin
      if (o_Mem_Addr < 17'd76800) begin
         i_Mem_Rdata <= ram[o_Mem_Addr];
         if (o_Mem_We) ram[o_Mem_Addr] <= o_Mem_Wdata;
      end else begin
         i_Mem_Rdata <= 9'h155;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one cycle of inputs, then move to just after the closing edge.
   task automatic drive(input int col, input int row);
      i_Col_Count = 10'(col);
      i_Row_Count = 10'(row);
      @(posedge i_Clk);
      #1;
   endtask

   task automatic host(input logic req, input logic we, input int addr, input int wdata);
      i_Host_Req   = req;
      i_Host_We    = we;
      i_Host_Addr  = 17'(addr);
      i_Host_Wdata = 9'(wdata);
   endtask

   initial begin
      for (int i = 0; i < 76800; i++) ram[i] = 9'(i);
      i_Mem_Rdata = '0;
      i_Rst   = 1'b1;
      i_HSync = 1'b1;
      i_VSync = 1'b1;
      // Request held during reset must not be granted.
      host(1'b1, 1'b1, 5, 9'h1ff);
      drive(0, 250);
      drive(1, 250);
      chk("rst_ack", o_Host_Ack, 0);
      chk("rst_mem_we", o_Mem_We, 0);
      chk("rst_mem_addr", o_Mem_Addr, 0);
      chk("rst_rvalid", o_Host_Rvalid, 0);
      chk("rst_rdata", o_Host_Rdata, 0);
      chk("rst_rgb", {o_Red_Video, o_Grn_Video, o_Blu_Video}, 0);
      chk("rst_hsync", o_HSync, 1);
      chk("rst_vsync", o_VSync, 1);
      host(1'b0, 1'b0, 0, 0);
      i_Rst = 1'b0;

      // Pixel fetch: row 0 fully, some blanking, then row 1 up to col 5.
      drive(0, 240);
      chk("vblank_hi", o_VBlank, 1);
      for (int c = 0; c < 320; c++) drive(c, 0);
      drive(320, 0);
      drive(321, 0);
      drive(322, 0);
      chk("idle_rgb_zero", {o_Red_Video, o_Grn_Video, o_Blu_Video}, 0);
      for (int c = 0; c < 5; c++) drive(c, 1);
      i_HSync = 1'b0;
      drive(5, 1);
      i_HSync = 1'b1;
      chk("fetch_addr_325", o_Mem_Addr, 325);
      chk("fetch_we", o_Mem_We, 0);
      chk("vblank_lo", o_VBlank, 0);
      drive(6, 1);
      chk("fetch_addr_326", o_Mem_Addr, 326);
      chk("hsync_d2", o_HSync, 1);
      drive(7, 1);
      chk("rgb_325", {o_Red_Video, o_Grn_Video, o_Blu_Video}, {3'd5, 3'd0, 3'd5});
      chk("hsync_d3", o_HSync, 0);
      drive(8, 1);
      chk("rgb_326", {o_Red_Video, o_Grn_Video, o_Blu_Video}, {3'd5, 3'd0, 3'd6});
      chk("hsync_d4", o_HSync, 1);

      // Host write requested mid-line: held off until the first blank column.
      host(1'b1, 1'b1, 1234, 9'h1ab);
      for (int c = 100; c < 320; c++) begin
         drive(c, 10);
         chk("act_no_ack", o_Host_Ack, 0);
         chk("act_no_we", o_Mem_We, 0);
      end
      drive(320, 10);
      chk("wr_ack", o_Host_Ack, 1);
      chk("wr_we", o_Mem_We, 1);
      chk("wr_addr", o_Mem_Addr, 1234);
      chk("wr_wdata", o_Mem_Wdata, 9'h1ab);
      host(1'b0, 1'b0, 0, 0);
      drive(321, 10);
      chk("wr_ack_pulse", o_Host_Ack, 0);
      chk("wr_we_pulse", o_Mem_We, 0);
      chk("wr_ram", ram[1234], 9'h1ab);

      // Out-of-range write and read.
      host(1'b1, 1'b1, 76800, 9'h0ff);
      drive(0, 241);
      chk("oor_wr_ack", o_Host_Ack, 1);
      chk("oor_wr_we", o_Mem_We, 0);
      host(1'b0, 1'b0, 0, 0);
      drive(1, 241);
      host(1'b1, 1'b0, 76800, 0);
      drive(2, 241);
      chk("oor_rd_ack", o_Host_Ack, 1);
      host(1'b0, 1'b0, 0, 0);
      drive(3, 241);
      chk("oor_rd_rvalid_early", o_Host_Rvalid, 0);
      drive(4, 241);
      chk("oor_rd_rvalid", o_Host_Rvalid, 1);
      chk("oor_rd_rdata", o_Host_Rdata, 0);

      // Host read of the last word, then read back the earlier write.
      host(1'b1, 1'b0, 76799, 0);
      drive(10, 242);
      chk("rd_ack", o_Host_Ack, 1);
      chk("rd_addr", o_Mem_Addr, 76799);
      host(1'b0, 1'b0, 0, 0);
      drive(11, 242);
      chk("rd_rvalid_c1", o_Host_Rvalid, 0);
      drive(12, 242);
      chk("rd_rvalid", o_Host_Rvalid, 1);
      chk("rd_rdata", o_Host_Rdata, 9'h1ff);
      host(1'b1, 1'b0, 1234, 0);
      drive(13, 242);
      chk("rd_rvalid_pulse", o_Host_Rvalid, 0);
      chk("rd_rdata_held", o_Host_Rdata, 9'h1ff);
      chk("rd2_ack", o_Host_Ack, 1);
      host(1'b0, 1'b0, 0, 0);
      drive(14, 242);
      drive(15, 242);
      chk("rd2_rdata", o_Host_Rdata, 9'h1ab);

      // Back-to-back: request held for 10 blanking cycles.
      acks = 0;
      host(1'b1, 1'b1, 100, 9'h042);
      for (int i = 0; i < 10; i++) begin
         drive(20 + i, 243);
         chk("b2b_ack", o_Host_Ack, (i % 2 == 0));
         acks += int'(o_Host_Ack);
      end
      chk("b2b_total", acks, 5);
      host(1'b0, 1'b0, 0, 0);
      drive(30, 243);

      // Reset the cycle after a read Ack: in-flight read must vanish.
      host(1'b1, 1'b0, 325, 0);
      i_HSync = 1'b0;
      i_VSync = 1'b0;
      drive(40, 244);
      chk("mid_ack", o_Host_Ack, 1);
      host(1'b0, 1'b0, 0, 0);
      i_Rst = 1'b1;
      drive(41, 244);
      i_Rst   = 1'b0;
      i_HSync = 1'b1;
      i_VSync = 1'b1;
      chk("mid_rst_ack", o_Host_Ack, 0);
      chk("mid_rst_addr", o_Mem_Addr, 0);
      chk("mid_rst_we", o_Mem_We, 0);
      chk("mid_rst_rdata", o_Host_Rdata, 0);
      chk("mid_rst_rgb", {o_Red_Video, o_Grn_Video, o_Blu_Video}, 0);
      chk("mid_rst_hsync", o_HSync, 1);
      chk("mid_rst_vsync", o_VSync, 1);
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_rvalid", o_Host_Rvalid, 0);
         chk("mid_no_ack", o_Host_Ack, 0);
         chk("mid_hsync", o_HSync, 1);
         drive(42 + i, 244);
      end
      chk("mid_no_rvalid_end", o_Host_Rvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
